// File: rtl/brg_vvadd_xcel_pkg.sv
// Shared types and helpers for the VVADD accelerator sequencing controller:
// FSM states, pairing-slot geometry and the request tag layout.
package brg_vvadd_xcel_pkg;

    localparam int SLOTS    = 16;
    localparam int SLOT_W   = 4;
    localparam int REG_ID_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        SIGNAL,
        WAIT_ACK,
        DONE
    } state_e;

    // Tag layout: {slot, is_b}; the low bit picks the operand half.
    function automatic logic [REG_ID_W-1:0] encode_reg_id(input logic [SLOT_W-1:0] slot,
                                                          input logic              is_b);
        return {slot, is_b};
    endfunction

    function automatic logic [SLOT_W-1:0] reg_id_slot(input logic [REG_ID_W-1:0] id);
        return id[REG_ID_W-1:1];
    endfunction

    function automatic logic reg_id_is_b(input logic [REG_ID_W-1:0] id);
        return id[0];
    endfunction

endpackage

// File: rtl/brg_vvadd_xcel_ctrl_if.sv
// Bundle of the network-tx request/return handshake and the result scratchpad
// write port driven by the VVADD sequencing controller.
interface brg_vvadd_xcel_ctrl_if #(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int max_out_credits_p = 4
);
    localparam int credit_counter_width_lp = $clog2(max_out_credits_p + 1);

    logic                               tx_v_o;
    logic                               tx_fetching_o;
    logic [addr_width_p-1:0]            tx_addr_o;
    logic [addr_width_p-1:0]            tx_signal_addr_o;
    logic [4:0]                         tx_reg_id_o;
    logic                               tx_ready_i;
    logic [credit_counter_width_lp-1:0] tx_credits_i;
    logic                               tx_returned_v_i;
    logic [data_width_p-1:0]            tx_returned_data_i;
    logic [4:0]                         tx_returned_reg_id_i;
    logic                               c_w_v_o;
    logic [addr_width_p-1:0]            c_w_addr_o;
    logic [data_width_p-1:0]            c_w_data_o;

    modport master (
        output tx_v_o, tx_fetching_o, tx_addr_o, tx_signal_addr_o, tx_reg_id_o,
        input  tx_ready_i, tx_credits_i,
        input  tx_returned_v_i, tx_returned_data_i, tx_returned_reg_id_i,
        output c_w_v_o, c_w_addr_o, c_w_data_o
    );

    modport slave (
        input  tx_v_o, tx_fetching_o, tx_addr_o, tx_signal_addr_o, tx_reg_id_o,
        output tx_ready_i, tx_credits_i,
        output tx_returned_v_i, tx_returned_data_i, tx_returned_reg_id_i,
        input  c_w_v_o, c_w_addr_o, c_w_data_o
    );

endinterface

// File: rtl/brg_vvadd_xcel_pair_buf.sv
// 16-entry operand pairing scoreboard: returns fill A/B halves in any order,
// the head slot reports ready once both halves are present and clears on retire.
module brg_vvadd_xcel_pair_buf
    import brg_vvadd_xcel_pkg::*;
#(
    parameter int data_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    w_v_i,
    input  logic [REG_ID_W-1:0]     w_reg_id_i,
    input  logic [data_width_p-1:0] w_data_i,
    input  logic [SLOT_W-1:0]       head_slot_i,
    input  logic                    retire_i,
    output logic                    head_ready_o,
    output logic [data_width_p-1:0] head_a_o,
    output logic [data_width_p-1:0] head_b_o
);

    logic [SLOTS-1:0]        a_v_q;
    logic [SLOTS-1:0]        b_v_q;
    logic [data_width_p-1:0] a_q [SLOTS];
    logic [data_width_p-1:0] b_q [SLOTS];
    logic [SLOT_W-1:0]       w_slot;
    logic                    w_is_b;

    assign w_slot = reg_id_slot(w_reg_id_i);
    assign w_is_b = reg_id_is_b(w_reg_id_i);

    // Retire and write never collide on one slot: retire needs both halves valid.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            a_v_q <= '0;
            b_v_q <= '0;
        end else begin
            if (retire_i) begin
                a_v_q[head_slot_i] <= 1'b0;
                b_v_q[head_slot_i] <= 1'b0;
            end
            if (w_v_i) begin
                if (w_is_b) b_v_q[w_slot] <= 1'b1;
                else        a_v_q[w_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            if (w_is_b) b_q[w_slot] <= w_data_i;
            else        a_q[w_slot] <= w_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && w_v_i) begin
            assert (!(w_is_b ? b_v_q[w_slot] : a_v_q[w_slot]));
        end
    end

    assign head_ready_o = a_v_q[head_slot_i] & b_v_q[head_slot_i];
    assign head_a_o     = a_q[head_slot_i];
    assign head_b_o     = b_q[head_slot_i];

endmodule

// File: rtl/brg_vvadd_xcel_ctrl.sv
// VVADD sequencing controller: issues A/B loads, pairs out-of-order returns,
// writes C[i] = A[i] + B[i] in index order, then sends the completion store.
module brg_vvadd_xcel_ctrl
    import brg_vvadd_xcel_pkg::*;
#(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int max_out_credits_p = 4,
    parameter int len_width_p       = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    go_i,
    input  logic [addr_width_p-1:0] a_base_i,
    input  logic [addr_width_p-1:0] b_base_i,
    input  logic [addr_width_p-1:0] sig_addr_i,
    input  logic [addr_width_p-1:0] c_base_i,
    input  logic [len_width_p-1:0]  len_i,
    output logic                    busy_o,
    output logic                    done_o,
    brg_vvadd_xcel_ctrl_if.master   tx_if
);

    localparam int credit_counter_width_lp = $clog2(max_out_credits_p + 1);

    state_e                  state_q;
    logic [len_width_p-1:0]  issue_idx_q;
    logic [len_width_p-1:0]  retire_idx_q;
    logic [len_width_p-1:0]  len_q;
    logic                    half_q;
    logic [addr_width_p-1:0] a_base_q;
    logic [addr_width_p-1:0] b_base_q;
    logic [addr_width_p-1:0] c_base_q;
    logic [addr_width_p-1:0] sig_q;

    logic                    active;
    logic                    have_credit;
    logic                    in_window;
    logic                    fetch_v;
    logic                    sig_v;
    logic                    head_ready;
    logic                    retire;
    logic [data_width_p-1:0] head_a;
    logic [data_width_p-1:0] head_b;

    assign active      = (state_q == FETCH) || (state_q == DRAIN);
    assign have_credit = tx_if.tx_credits_i != '0;
    // Slot issue_idx mod 16 is free only once element issue_idx-16 has retired.
    assign in_window   = (issue_idx_q - retire_idx_q) < len_width_p'(SLOTS);
    assign fetch_v     = (state_q == FETCH) && have_credit && (issue_idx_q < len_q) && in_window;
    assign sig_v       = (state_q == SIGNAL) && have_credit;
    assign retire      = active && head_ready;

    assign tx_if.tx_v_o           = fetch_v || sig_v;
    assign tx_if.tx_fetching_o    = state_q != SIGNAL;
    assign tx_if.tx_addr_o        = (state_q == FETCH)
                                  ? (half_q ? b_base_q : a_base_q) + addr_width_p'(issue_idx_q)
                                  : '0;
    assign tx_if.tx_reg_id_o      = (state_q == FETCH)
                                  ? encode_reg_id(issue_idx_q[SLOT_W-1:0], half_q)
                                  : '0;
    assign tx_if.tx_signal_addr_o = sig_q;

    assign tx_if.c_w_v_o    = retire;
    assign tx_if.c_w_addr_o = retire ? c_base_q + addr_width_p'(retire_idx_q) : '0;
    assign tx_if.c_w_data_o = retire ? head_a + head_b : '0;

    assign busy_o = state_q != IDLE;
    assign done_o = state_q == DONE;

    brg_vvadd_xcel_pair_buf #(
        .data_width_p(data_width_p)
    ) u_pair_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clear_i     ((state_q == IDLE) && go_i),
        .w_v_i       (active && tx_if.tx_returned_v_i),
        .w_reg_id_i  (tx_if.tx_returned_reg_id_i),
        .w_data_i    (tx_if.tx_returned_data_i),
        .head_slot_i (retire_idx_q[SLOT_W-1:0]),
        .retire_i    (retire),
        .head_ready_o(head_ready),
        .head_a_o    (head_a),
        .head_b_o    (head_b)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            issue_idx_q  <= '0;
            retire_idx_q <= '0;
            len_q        <= '0;
            half_q       <= 1'b0;
            a_base_q     <= '0;
            b_base_q     <= '0;
            c_base_q     <= '0;
            sig_q        <= '0;
        end else begin
            if (retire) retire_idx_q <= retire_idx_q + len_width_p'(1);
            // A goes out first; the element index advances once B is accepted.
            if (fetch_v && tx_if.tx_ready_i) begin
                half_q <= ~half_q;
                if (half_q) issue_idx_q <= issue_idx_q + len_width_p'(1);
            end
            case (state_q)
                IDLE: begin
                    if (go_i) begin
                        a_base_q     <= a_base_i;
                        b_base_q     <= b_base_i;
                        c_base_q     <= c_base_i;
                        sig_q        <= sig_addr_i;
                        len_q        <= len_i;
                        issue_idx_q  <= '0;
                        retire_idx_q <= '0;
                        half_q       <= 1'b0;
                        state_q      <= (len_i == '0) ? SIGNAL : FETCH;
                    end
                end
                FETCH: begin
                    if (issue_idx_q == len_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if ((retire_idx_q == len_q) &&
                        (tx_if.tx_credits_i == credit_counter_width_lp'(max_out_credits_p)))
                        state_q <= SIGNAL;
                end
                SIGNAL: begin
                    if (sig_v && tx_if.tx_ready_i) state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_if.tx_returned_v_i) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brg_vvadd_xcel_ctrl.sv
// Scoreboard bench for brg_vvadd_xcel_ctrl: a behavioural network endpoint with
// credits and reorderable returns, and an expected-write queue for C.
module tb_brg_vvadd_xcel_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int MAXC = 4;
    localparam int LW   = 16;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [AW-1:0] A_BASE = 16'h0100;
    localparam logic [AW-1:0] B_BASE = 16'h0200;
    localparam logic [AW-1:0] C_BASE = 16'h0300;
    localparam logic [AW-1:0] SIG    = 16'h0400;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          fetching;
        logic [4:0]    id;
    } req_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          go_i;
    logic [AW-1:0] a_base_i, b_base_i, sig_addr_i, c_base_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o;

    brg_vvadd_xcel_ctrl_if #(.data_width_p(DW), .addr_width_p(AW), .max_out_credits_p(MAXC)) bus ();

    brg_vvadd_xcel_ctrl #(
        .data_width_p(DW), .addr_width_p(AW), .max_out_credits_p(MAXC), .len_width_p(LW)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .go_i      (go_i),
        .a_base_i  (a_base_i),
        .b_base_i  (b_base_i),
        .sig_addr_i(sig_addr_i),
        .c_base_i  (c_base_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .tx_if     (bus)
    );

    always #5 clk = ~clk;

    req_t          pend_q[$];
    wr_t           exp_q[$];
    logic [DW-1:0] a_mem [64];
    logic [DW-1:0] b_mem [64];
    int checks = 0, errors = 0;
    int outstanding = 0, loads = 0, stores = 0, done_cnt = 0;
    int hold_cnt = 0, ret_mode = 0, rdy_rand = 0, issue_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        if (addr >= B_BASE) begin
            off = addr - B_BASE;
            return b_mem[off[5:0]];
        end
        off = addr - A_BASE;
        return a_mem[off[5:0]];
    endfunction

    // One cycle: drive endpoint inputs on the falling edge, then observe.
    task automatic tick();
        req_t          r;
        int            k;
        logic          ret_now;
        logic [AW-1:0] idx;
        logic [4:0]    eid;
        @(negedge clk);
        ret_now = 1'b0;
        bus.tx_returned_v_i      = 1'b0;
        bus.tx_returned_data_i   = '0;
        bus.tx_returned_reg_id_i = '0;
        if (pend_q.size() > 0 && (ret_mode != 2 || $urandom_range(0, 1) == 1)) begin
            if (ret_mode == 1) r = pend_q.pop_back();
            else if (ret_mode == 2) begin
                k = $urandom_range(0, pend_q.size() - 1);
                r = pend_q[k];
                pend_q.delete(k);
            end else r = pend_q.pop_front();
            bus.tx_returned_v_i      = 1'b1;
            bus.tx_returned_reg_id_i = r.id;
            bus.tx_returned_data_i   = r.fetching ? mem_val(r.addr) : '0;
            ret_now = 1'b1;
        end
        bus.tx_credits_i = (hold_cnt > 0) ? '0 : CW'(MAXC - outstanding);
        bus.tx_ready_i   = rdy_rand != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        if (!reset_i) begin
            if (hold_cnt > 0) check("tx_v_no_credit", bus.tx_v_o, 0);
            if (bus.tx_v_o && bus.tx_ready_i) begin
                check("credit_bound", outstanding < MAXC, 1);
                r.fetching = bus.tx_fetching_o;
                r.id       = bus.tx_reg_id_o;
                if (bus.tx_fetching_o) begin
                    idx = AW'(issue_cnt >> 1);
                    eid = {idx[3:0], issue_cnt[0]};
                    check("tx_addr", bus.tx_addr_o, (issue_cnt[0] ? B_BASE : A_BASE) + idx);
                    check("tx_tag", bus.tx_reg_id_o, eid);
                    r.addr = bus.tx_addr_o;
                    loads++;
                    issue_cnt++;
                end else begin
                    check("sig_addr", bus.tx_signal_addr_o, SIG);
                    check("sig_tag", bus.tx_reg_id_o, 0);
                    r.addr = bus.tx_signal_addr_o;
                    stores++;
                end
                pend_q.push_back(r);
                outstanding++;
            end
            if (bus.c_w_v_o) begin
                if (exp_q.size() == 0) check("c_w_unexpected", bus.c_w_v_o, 0);
                else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("c_w_addr", bus.c_w_addr_o, w.addr);
                    check("c_w_data", bus.c_w_data_o, w.data);
                end
            end
            if (done_o) done_cnt++;
        end
        if (ret_now) outstanding--;
        if (hold_cnt > 0) hold_cnt--;
    endtask

    task automatic reset_checks();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_tx_v", bus.tx_v_o, 0);
        check("rst_fetching", bus.tx_fetching_o, 1);
        check("rst_tx_addr", bus.tx_addr_o, 0);
        check("rst_tx_tag", bus.tx_reg_id_o, 0);
        check("rst_sig_addr", bus.tx_signal_addr_o, 0);
        check("rst_c_w_v", bus.c_w_v_o, 0);
        check("rst_c_w_addr", bus.c_w_addr_o, 0);
        check("rst_c_w_data", bus.c_w_data_o, 0);
    endtask

    task automatic run_op(input int len, input int rmode, input int rrand,
                          input int hold_at, input int go_at, input int reset_at);
        logic [DW-1:0] s;
        int            cyc;
        ret_mode = rmode;
        rdy_rand = rrand;
        len_i = LW'(len);
        a_base_i = A_BASE; b_base_i = B_BASE; c_base_i = C_BASE; sig_addr_i = SIG;
        for (int i = 0; i < len; i++) begin
            s = a_mem[i] + b_mem[i];
            exp_q.push_back({C_BASE + AW'(i), s});
        end
        loads = 0; stores = 0; done_cnt = 0; issue_cnt = 0;
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
        check("busy_after_go", busy_o, 1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            if (cyc == go_at) begin
                go_i  = 1'b1;
                len_i = LW'(len + 5);
            end else go_i = 1'b0;
            if (cyc == hold_at) hold_cnt = 10;
            if (cyc == reset_at) begin
                reset_i = 1'b1;
                tick();
                reset_checks();
                reset_i = 1'b0;
                exp_q.delete();
                for (int c = 0; c < 200 && pend_q.size() > 0; c++) tick();
                check("stray_drained", pend_q.size(), 0);
                check("idle_after_strays", busy_o, 0);
                return;
            end
            tick();
            cyc++;
        end
        go_i = 1'b0;
        check("done_seen", done_cnt, 1);
        tick();
        check("idle_after_done", busy_o, 0);
        check("done_one_cycle", done_o, 0);
        check("load_count", loads, 2 * len);
        check("store_count", stores, 1);
        check("c_writes_left", exp_q.size(), 0);
    endtask

    initial begin
        reset_i = 1'b1; go_i = 1'b0; len_i = '0;
        a_base_i = '0; b_base_i = '0; c_base_i = '0; sig_addr_i = '0;
        bus.tx_ready_i = 1'b0; bus.tx_credits_i = '0;
        bus.tx_returned_v_i = 1'b0; bus.tx_returned_data_i = '0; bus.tx_returned_reg_id_i = '0;
        tick();
        tick();
        reset_checks();
        reset_i = 1'b0;

        for (int i = 0; i < 64; i++) begin a_mem[i] = DW'(i + 1); b_mem[i] = DW'(10 * (i + 1)); end
        run_op(4, 0, 0, -1, -1, -1);

        for (int i = 0; i < 64; i++) begin a_mem[i] = DW'(3 * i); b_mem[i] = DW'(100 + i); end
        run_op(16, 1, 0, -1, -1, -1);

        run_op(12, 0, 0, 5, -1, -1);

        for (int i = 0; i < 64; i++) begin a_mem[i] = 8'hFF; b_mem[i] = 8'h02; end
        run_op(40, 2, 1, -1, -1, -1);

        run_op(0, 0, 0, -1, -1, -1);

        for (int i = 0; i < 64; i++) begin a_mem[i] = DW'(7 * i); b_mem[i] = DW'(i); end
        run_op(10, 2, 0, -1, 4, -1);

        run_op(20, 0, 0, -1, -1, 9);
        run_op(8, 2, 1, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
